systolic_controller: RTL and testbench
======================================

SYSTOLIC_CONTROLLER -- requirements
Module: systolic_controller

Interface
REQ-001 Parameter NUM_PE, default 64: number of PE result registers read back.
REQ-002 Parameter PE_W, default 24: width of one PE result register in bits; SHALL be a multiple of 8.
REQ-003 Parameter FEED_CYCLES, default 16: cycles the SRAMs stream operands into the array.
REQ-004 Parameter FLUSH_CYCLES, default 15: cycles of zero-operand drain after feed; FEED_CYCLES+FLUSH_CYCLES SHALL be <= 64.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-007 start  input  1  request one compute-and-readout job; sampled only in IDLE.
REQ-008 pe_register_vals  input  NUM_PE*PE_W  packed PE results, PE k at bits [k*PE_W +: PE_W].
REQ-009 tx_ready  input  1  UART transmitter can accept a byte.
REQ-010 sram_en  output  1  enables weight and activation SRAM read streaming.
REQ-011 array_clr  output  1  one-cycle synchronous clear of array accumulators.
REQ-012 cycles_count  output  6  compute cycle index driven to the systolic array.
REQ-013 compute_done  output  1  array results valid and stable.
REQ-014 tx_data  output  8  byte presented to UART transmitter.
REQ-015 tx_valid  output  1  tx_data valid.
REQ-016 busy  output  1  job in progress (any state but IDLE).
REQ-017 done  output  1  one-cycle pulse at job completion.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, FEED, FLUSH, SEND, DONE.
REQ-019 IDLE -> CLEAR when start=1; start in any other state SHALL be ignored.
REQ-020 CLEAR lasts exactly 1 cycle with array_clr=1, cycles_count=0, then -> FEED.
REQ-021 FEED lasts FEED_CYCLES cycles with sram_en=1; cycles_count = 0..FEED_CYCLES-1, +1 per cycle.
REQ-022 FLUSH lasts FLUSH_CYCLES cycles with sram_en=0; cycles_count continues FEED_CYCLES..FEED_CYCLES+FLUSH_CYCLES-1.
REQ-023 On FLUSH exit, cycles_count SHALL hold its final value and compute_done SHALL go 1 and stay 1 until next CLEAR entry.
REQ-024 SEND serializes NUM_PE*PE_W/8 bytes: PE index 0 first, each PE least-significant byte first.
REQ-025 tx_valid=1 throughout SEND; a byte transfers on a cycle with tx_valid=1 and tx_ready=1; tx_data SHALL stay stable until transferred.
REQ-026 Byte index and PE index advance only on transfer; after the final byte transfers -> DONE.
REQ-027 DONE lasts 1 cycle with done=1, then -> IDLE; start in DONE SHALL be ignored.
REQ-028 tx_ready=0 for any duration SHALL stall SEND without loss or duplication of bytes.
REQ-029 tx_ready=1 continuously SHALL give exactly one byte per cycle.
REQ-030 pe_register_vals SHALL be sampled combinationally per byte; the array holds results stable while compute_done=1.
REQ-031 Job latency start-to-done with tx_ready always 1 SHALL be 1+FEED_CYCLES+FLUSH_CYCLES+NUM_PE*PE_W/8+1 cycles after the start-sampling edge (225 at defaults).

Reset
REQ-032 reset=0 SHALL asynchronously force IDLE, counters 0, and outputs sram_en=0, array_clr=0, cycles_count=0, compute_done=0, tx_data=0, tx_valid=0, busy=0, done=0.
REQ-033 reset asserted mid-job (any state) SHALL abort the job; no further bytes or done pulse issued until a new start.
REQ-034 After reset release, first start SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-035 Reset then start=1 one cycle, tx_ready=1 -> array_clr one pulse, sram_en high 16 cycles, cycles_count 0..30, compute_done rises, 192 bytes, done pulse at cycle 225.
REQ-036 pe_register_vals PE0=0x123456, PE63=0xABCDEF -> first three bytes 0x56,0x34,0x12; last three 0xEF,0xCD,0xAB.
REQ-037 tx_ready toggled 1/0 each cycle in SEND -> 192 distinct bytes in order, tx_data stable while tx_ready=0, SEND spans 383 cycles.
REQ-038 start pulsed during FEED and during DONE -> ignored; exactly one done pulse; busy low after DONE.
REQ-039 reset=0 at cycle 10 of SEND -> all outputs 0 immediately; subsequent start runs full 192-byte job from PE0 byte 0.
REQ-040 start held high continuously -> back-to-back jobs with exactly one IDLE cycle between done pulse and next array_clr.

Source files
------------

// File: rtl/systolic_controller.sv
// Sequences one systolic-array job: clear the accumulators, stream operands, drain
// the pipeline, then serialize every PE result register to a UART byte stream.
module systolic_controller #(
  parameter int unsigned NUM_PE       = 64,
  parameter int unsigned PE_W         = 24,
  parameter int unsigned FEED_CYCLES  = 16,
  parameter int unsigned FLUSH_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_PE*PE_W-1:0] pe_register_vals,
  input  logic                   tx_ready,
  output logic                   sram_en,
  output logic                   array_clr,
  output logic [5:0]             cycles_count,
  output logic                   compute_done,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CNT_W        = 6;
  localparam int unsigned BYTES_PER_PE = PE_W / 8;
  localparam int unsigned VALS_W       = NUM_PE * PE_W;
  localparam int unsigned SEL_W        = $clog2(VALS_W);
  localparam int unsigned PE_IDX_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int unsigned BYTE_IDX_W   = (BYTES_PER_PE > 1) ? $clog2(BYTES_PER_PE) : 1;

  localparam logic [CNT_W-1:0]      FEED_LAST  = CNT_W'(FEED_CYCLES - 1);
  localparam logic [CNT_W-1:0]      FLUSH_LAST = CNT_W'(FEED_CYCLES + FLUSH_CYCLES - 1);
  localparam logic [PE_IDX_W-1:0]   PE_LAST    = PE_IDX_W'(NUM_PE - 1);
  localparam logic [BYTE_IDX_W-1:0] BYTE_LAST  = BYTE_IDX_W'(BYTES_PER_PE - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    SEND,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cycles_count_q, cycles_count_d;
  logic [PE_IDX_W-1:0]   pe_idx_q, pe_idx_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic                  compute_done_q, compute_done_d;
  logic                  sram_en_q, sram_en_d;
  logic                  array_clr_q, array_clr_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [SEL_W-1:0]      tx_base;

  // Next-state, counters, and output flags derived from the state being entered
  always_comb begin
    state_d        = state_q;
    cycles_count_d = cycles_count_q;
    pe_idx_d       = pe_idx_q;
    byte_idx_d     = byte_idx_q;
    compute_done_d = compute_done_q;

    case (state_q)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: state_d = FEED;
      FEED: begin
        cycles_count_d = cycles_count_q + CNT_W'(1);
        if (cycles_count_q == FEED_LAST) state_d = FLUSH;
      end
      FLUSH: begin
        if (cycles_count_q == FLUSH_LAST) state_d = SEND;
        else cycles_count_d = cycles_count_q + CNT_W'(1);
      end
      SEND: begin
        if (tx_ready) begin
          if (byte_idx_q == BYTE_LAST) begin
            byte_idx_d = '0;
            if (pe_idx_q == PE_LAST) begin
              pe_idx_d = '0;
              state_d  = DONE;
            end else begin
              pe_idx_d = pe_idx_q + PE_IDX_W'(1);
            end
          end else begin
            byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Results stay flagged valid from the end of the drain until the next clear
    if (state_d == SEND) compute_done_d = 1'b1;
    if (state_d == CLEAR) begin
      cycles_count_d = '0;
      compute_done_d = 1'b0;
      pe_idx_d       = '0;
      byte_idx_d     = '0;
    end

    sram_en_d   = (state_d == FEED);
    array_clr_d = (state_d == CLEAR);
    tx_valid_d  = (state_d == SEND);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cycles_count_q <= '0;
      pe_idx_q       <= '0;
      byte_idx_q     <= '0;
      compute_done_q <= 1'b0;
      sram_en_q      <= 1'b0;
      array_clr_q    <= 1'b0;
      tx_valid_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cycles_count_q <= cycles_count_d;
      pe_idx_q       <= pe_idx_d;
      byte_idx_q     <= byte_idx_d;
      compute_done_q <= compute_done_d;
      sram_en_q      <= sram_en_d;
      array_clr_q    <= array_clr_d;
      tx_valid_q     <= tx_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  // Byte picked live from the held array results, LSB first within each PE
  always_comb begin
    tx_base = SEL_W'(pe_idx_q) * SEL_W'(PE_W) + SEL_W'(byte_idx_q) * SEL_W'(8);
    tx_data = tx_valid_q ? 8'(pe_register_vals >> tx_base) : 8'h00;
  end

  assign sram_en      = sram_en_q;
  assign array_clr    = array_clr_q;
  assign cycles_count = cycles_count_q;
  assign compute_done = compute_done_q;
  assign tx_valid     = tx_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_systolic_controller.sv
// Scoreboard bench for systolic_controller: expected UART bytes are queued when a
// job is issued and popped by an independent monitor on every transfer.
`timescale 1ns/1ps
module tb_systolic_controller;

  localparam int unsigned NPE = 64;
  localparam int unsigned PW  = 24;
  localparam int unsigned FC  = 16;
  localparam int unsigned FL  = 15;
  localparam int unsigned VW  = NPE * PW;
  localparam int unsigned NB  = NPE * PW / 8;
  localparam int          LAT = 1 + FC + FL + NB + 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic [VW-1:0] pe_vals;
  logic          tx_ready;
  logic          sram_en, array_clr, compute_done, tx_valid, busy, done;
  logic [5:0]    cycles_count;
  logic [7:0]    tx_data;

  systolic_controller #(
    .NUM_PE(NPE), .PE_W(PW), .FEED_CYCLES(FC), .FLUSH_CYCLES(FL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pe_register_vals(pe_vals),
    .tx_ready(tx_ready), .sram_en(sram_en), .array_clr(array_clr),
    .cycles_count(cycles_count), .compute_done(compute_done), .tx_data(tx_data),
    .tx_valid(tx_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] byte_log[$];
  logic [5:0] cc_log[$];
  int clr_cyc = 0, done_cyc = 0, last_done_cyc = -1, gap = -1;
  int sram_cnt = 0, valid_cnt = 0, xfer_cnt = 0, done_cnt = 0, clr_cnt = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int tx_mode = 0;
  int send_idx = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [VW-1:0] rand_vals();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(VW / 32); i++) v = {v[VW-33:0], 32'($urandom())};
    return v;
  endfunction

  // Reference model: PE 0 first, each PE least-significant byte first
  task automatic push_job(input logic [VW-1:0] v);
    for (int k = 0; k < int'(NPE); k++)
      for (int b = 0; b < int'(PW / 8); b++)
        exp_q.push_back(8'(v >> (k * int'(PW) + b * 8)));
  endtask

  task automatic check_zero(input string name);
    check(name, 64'({sram_en, array_clr, cycles_count, compute_done, tx_data, tx_valid, busy, done}),
          64'(0));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // UART sink: 0 = always ready, 1 = ready on alternate SEND cycles, 2 = random
  always @(posedge clk) begin
    #1;
    if (tx_valid === 1'b1) begin
      case (tx_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (send_idx % 2 == 0);
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
      send_idx++;
    end else begin
      send_idx = 0;
      tx_ready = 1'b1;
    end
  end

  // Monitor: scoreboard pops and per-job statistics
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (array_clr === 1'b1) begin
        check("clr_compute_done", 64'(compute_done), 64'(0));
        if (last_done_cyc >= 0) gap = cyc - last_done_cyc;
        clr_cyc = cyc;
        clr_cnt++;
        sram_cnt = 0; valid_cnt = 0; xfer_cnt = 0;
        cc_log.delete();
        byte_log.delete();
      end
      if (busy === 1'b1 && compute_done === 1'b0) cc_log.push_back(cycles_count);
      if (sram_en === 1'b1) sram_cnt++;
      if (tx_valid === 1'b1) begin
        valid_cnt++;
        check("send_compute_done", 64'(compute_done), 64'(1));
        if (prev_stall) check("stall_hold", 64'(tx_data), 64'(prev_data));
        if (tx_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_byte: got 0x%02h, want no byte (t=%0t)", tx_data, $time);
          end else begin
            check("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
          end
          byte_log.push_back(tx_data);
          xfer_cnt++;
        end
      end
      prev_stall = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
      prev_data  = tx_data;
      if (done === 1'b1) begin
        check("done_byte_count", 64'(xfer_cnt), 64'(NB));
        done_cnt++;
        done_cyc = cyc;
        last_done_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Waits for the done pulse of a job already past CLEAR, then audits it
  task automatic finish_job(input int mode, input int d0, input int c0, input bit poke_feed,
                            input bit poke_done);
    int t;
    bit poked;
    bit ok;
    t = 0;
    poked = 1'b0;
    while (done !== 1'b1 && t < 3000) begin
      start = poke_feed && (sram_en === 1'b1) && !poked;
      if (start) poked = 1'b1;
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    if (t >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done pulse, want one within 3000 cycles");
    end
    check("done_cycles_count", 64'(cycles_count), 64'(FC + FL - 1));
    check("done_compute_done", 64'(compute_done), 64'(1));
    if (poke_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_compute_done", 64'(compute_done), 64'(1));
    check("done_pulses", 64'(done_cnt - d0), 64'(1));
    check("clear_pulses", 64'(clr_cnt - c0), 64'(1));
    check("feed_cycles", 64'(sram_cnt), 64'(FC));
    ok = (cc_log.size() == FC + FL + 1);
    for (int i = 0; i < cc_log.size() && ok; i++)
      if (int'(cc_log[i]) != ((i == 0) ? 0 : i - 1)) ok = 1'b0;
    check("cycles_count_trace", 64'(ok), 64'(1));
    if (mode == 0) begin
      check("job_latency", 64'(done_cyc - clr_cyc + 1), 64'(LAT));
      check("send_span", 64'(valid_cnt), 64'(NB));
    end else if (mode == 1) begin
      check("send_span", 64'(valid_cnt), 64'(2 * NB - 1));
    end
  endtask

  task automatic run_job(input int mode, input logic [VW-1:0] v, input bit poke_feed,
                         input bit poke_done);
    int d0, c0;
    tx_mode = mode;
    pe_vals = v;
    push_job(v);
    d0 = done_cnt;
    c0 = clr_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_job(mode, d0, c0, poke_feed, poke_done);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [VW-1:0] v;
    int d0, c0, t, seen;

    reset = 1'b0; start = 1'b0; pe_vals = '0; tx_ready = 1'b1;
    #3;
    check_zero("reset_outputs");
    repeat (3) @(negedge clk);
    check_zero("reset_hold");
    reset = 1'b1;

    // Known corner PEs, ready always high
    v = rand_vals();
    v[PW-1:0] = 24'h123456;
    v[VW-1 -: PW] = 24'hABCDEF;
    run_job(0, v, 1'b0, 1'b0);
    check("byte_log_size", 64'(byte_log.size()), 64'(NB));
    if (byte_log.size() == NB) begin
      check("first_byte0", 64'(byte_log[0]), 64'(8'h56));
      check("first_byte1", 64'(byte_log[1]), 64'(8'h34));
      check("first_byte2", 64'(byte_log[2]), 64'(8'h12));
      check("last_byte0", 64'(byte_log[NB-3]), 64'(8'hEF));
      check("last_byte1", 64'(byte_log[NB-2]), 64'(8'hCD));
      check("last_byte2", 64'(byte_log[NB-1]), 64'(8'hAB));
    end

    // Alternating ready, then random ready with stray starts in FEED and DONE
    run_job(1, rand_vals(), 1'b0, 1'b0);
    run_job(2, rand_vals(), 1'b1, 1'b1);

    // Abort mid-SEND, then a fresh job straight out of reset
    v = rand_vals();
    tx_mode = 0;
    pe_vals = v;
    push_job(v);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    t = 0;
    while (xfer_cnt < 10 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("abort_reached_send", 64'(t < 1000), 64'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_zero("abort_async");
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_zero("abort_hold");
    v = rand_vals();
    pe_vals = v;
    push_job(v);
    c0 = clr_cnt;
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_start_after_reset", 64'(array_clr), 64'(1));
    finish_job(0, d0, c0, 1'b0, 1'b0);

    // Start held high: two jobs back to back
    v = rand_vals();
    pe_vals = v;
    tx_mode = 0;
    push_job(v);
    push_job(v);
    d0 = done_cnt;
    c0 = clr_cnt;
    @(negedge clk);
    start = 1'b1;
    t = 0;
    seen = 0;
    while (seen < 2 && t < 3000) begin
      @(negedge clk);
      t++;
      if (done === 1'b1) seen++;
    end
    start = 1'b0;
    check("b2b_done_seen", 64'(seen), 64'(2));
    repeat (3) @(negedge clk);
    check("b2b_idle_gap", 64'(gap), 64'(2));
    check("b2b_done_pulses", 64'(done_cnt - d0), 64'(2));
    check("b2b_clear_pulses", 64'(clr_cnt - c0), 64'(2));
    check("b2b_queue_drained", 64'(exp_q.size()), 64'(0));
    check("b2b_busy", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
